// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared control-bundle types, opcode constants and decode function
//   ctrl_t       : registered control bundle handed to execute
//   decode_t     : ctrl_t plus an unsupported-encoding flag
//   decode_ctrl  : opcode/funct3/funct7 -> decode_t (ctrl forced to zero when illegal)
package riscv_ctrl_pkg;

    typedef struct packed {
        logic [3:0] immSel;
        logic       brmuxsel;
        logic       br_signed;
        logic       is_branch;
        logic       is_jump;
        logic       jalr_clear_lsb;
        logic       aluop1sel;
        logic       aluop2sel;
        logic [3:0] ALUctrl;
        logic       MemWr;
        logic       regWE;
        logic       load;
        logic [1:0] WBSel;
        logic       slt_op;
        logic       res_station_valid;
        logic       store_cond;
    } ctrl_t;

    typedef struct packed {
        ctrl_t ctrl;
        logic  illegal;
    } decode_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_AMO    = 7'b0101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [4:0] AMO_LR  = 5'b00010;
    localparam logic [4:0] AMO_SC  = 5'b00011;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_STORE = 2'b01;
    localparam logic [1:0] MEM_LR    = 2'b10;
    localparam logic [1:0] MEM_SC    = 2'b11;

    function automatic decode_t decode_ctrl(input logic [6:0] opcode,
                                            input logic [2:0] funct3,
                                            input logic [6:0] funct7);
        decode_t d;
        d = '0;
        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                d.ctrl.WBSel   = 2'b01;
                d.ctrl.regWE   = 1'b1;
                d.ctrl.ALUctrl = 4'b0010;
                // Only register-register SUB selects the subtract ALU op;
                // SRA/SRAI share funct7 but stay on the shift path.
                if (opcode == OPC_OP && funct7 == F7_ALT && funct3 == 3'b000)
                    d.ctrl.ALUctrl = 4'b0001;
                if (funct3 == 3'b010) begin
                    d.ctrl.slt_op    = 1'b1;
                    d.ctrl.br_signed = 1'b1;
                    d.ctrl.WBSel     = 2'b11;
                end
                if (funct3 == 3'b011) begin
                    d.ctrl.slt_op = 1'b1;
                    d.ctrl.WBSel  = 2'b11;
                end
                if (opcode == OPC_OP_IMM) begin
                    d.ctrl.immSel    = 4'b0001;
                    d.ctrl.aluop2sel = 1'b1;
                    d.ctrl.brmuxsel  = 1'b1;
                end
                // funct7 carries immediate bits for OP-IMM, so only OP checks it.
                if (opcode == OPC_OP && funct7 != F7_BASE && funct7 != F7_ALT)
                    d.illegal = 1'b1;
            end
            OPC_LOAD: begin
                d.ctrl.load      = 1'b1;
                d.ctrl.immSel    = 4'b0001;
                d.ctrl.aluop2sel = 1'b1;
                d.ctrl.regWE     = 1'b1;
            end
            OPC_STORE: begin
                d.ctrl.immSel    = 4'b0010;
                d.ctrl.aluop2sel = 1'b1;
                d.ctrl.MemWr     = 1'b1;
            end
            OPC_BRANCH: begin
                d.ctrl.immSel    = 4'b0011;
                d.ctrl.aluop1sel = 1'b1;
                d.ctrl.aluop2sel = 1'b1;
                d.ctrl.is_branch = 1'b1;
                d.ctrl.br_signed = (funct3 == 3'b100) || (funct3 == 3'b101);
            end
            OPC_JAL: begin
                d.ctrl.is_jump   = 1'b1;
                d.ctrl.immSel    = 4'b0100;
                d.ctrl.aluop1sel = 1'b1;
                d.ctrl.aluop2sel = 1'b1;
                d.ctrl.WBSel     = 2'b10;
                d.ctrl.regWE     = 1'b1;
            end
            OPC_JALR: begin
                d.ctrl.is_jump        = 1'b1;
                d.ctrl.immSel         = 4'b0001;
                d.ctrl.aluop2sel      = 1'b1;
                d.ctrl.WBSel          = 2'b10;
                d.ctrl.regWE          = 1'b1;
                d.ctrl.jalr_clear_lsb = 1'b1;
            end
            OPC_LUI: begin
                d.ctrl.aluop2sel = 1'b1;
                d.ctrl.ALUctrl   = 4'b0011;
                d.ctrl.WBSel     = 2'b01;
                d.ctrl.regWE     = 1'b1;
            end
            OPC_AUIPC: begin
                d.ctrl.aluop1sel = 1'b1;
                d.ctrl.aluop2sel = 1'b1;
                d.ctrl.WBSel     = 2'b01;
                d.ctrl.regWE     = 1'b1;
            end
            OPC_SYSTEM: begin
                d.ctrl.immSel    = 4'b0101;
                d.ctrl.aluop2sel = 1'b1;
                d.ctrl.ALUctrl   = 4'b0011;
                d.ctrl.WBSel     = 2'b01;
                d.ctrl.regWE     = 1'b1;
            end
            OPC_AMO: begin
                // funct7[1:0] are aq/rl ordering bits and do not affect decode.
                if (funct7[6:2] == AMO_LR) begin
                    d.ctrl.load              = 1'b1;
                    d.ctrl.res_station_valid = 1'b1;
                    d.ctrl.immSel            = 4'b0110;
                    d.ctrl.aluop2sel         = 1'b1;
                    d.ctrl.regWE             = 1'b1;
                end else if (funct7[6:2] == AMO_SC) begin
                    d.ctrl.store_cond = 1'b1;
                    d.ctrl.immSel     = 4'b0110;
                    d.ctrl.aluop2sel  = 1'b1;
                    d.ctrl.regWE      = 1'b1;
                    d.ctrl.WBSel      = 2'b11;
                end else begin
                    d.illegal = 1'b1;
                end
            end
            default: d.illegal = 1'b1;
        endcase
        if (d.illegal)
            d.ctrl = '0;
        return d;
    endfunction

endpackage

// File: rtl/lrsc_reservation_table.sv
// rtl/lrsc_reservation_table.sv - per-hart LR/SC reservation table with registered SC result
//   i_clk, i_rstn                : clock, asynchronous active-low reset
//   i_mem_valid/_hart_id/_addr/_op : one memory-stage op per cycle (none/store/LR/SC)
//   o_sc_done/_hart_id/_success  : SC resolution, one cycle after the SC
//   o_res_valid                  : reservation-valid bit per hart
module lrsc_reservation_table
    import riscv_ctrl_pkg::*;
#(
    parameter int NUM_HARTS   = 16,
    parameter int HART_ID_W   = $clog2(NUM_HARTS),
    parameter int ADDR_W      = 32,
    parameter int RES_GRANULE = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_mem_valid,
    input  logic [HART_ID_W-1:0] i_mem_hart_id,
    input  logic [ADDR_W-1:0]    i_mem_addr,
    input  logic [1:0]           i_mem_op,
    output logic                 o_sc_done,
    output logic [HART_ID_W-1:0] o_sc_hart_id,
    output logic                 o_sc_success,
    output logic [NUM_HARTS-1:0] o_res_valid
);

    localparam int TAG_W = ADDR_W - RES_GRANULE;

    logic [NUM_HARTS-1:0] res_valid;
    logic [NUM_HARTS-1:0] res_valid_nxt;
    logic [NUM_HARTS-1:0] tag_match;
    logic [NUM_HARTS-1:0] issuer;
    logic [TAG_W-1:0]     res_tag [NUM_HARTS];
    logic [TAG_W-1:0]     mem_tag;
    logic                 is_store;
    logic                 is_lr;
    logic                 is_sc;
    logic                 sc_ok;
    logic                 unused_addr_lo;

    assign mem_tag        = i_mem_addr[ADDR_W-1:RES_GRANULE];
    assign unused_addr_lo = ^i_mem_addr[RES_GRANULE-1:0];
    assign issuer         = {{(NUM_HARTS-1){1'b0}}, 1'b1} << i_mem_hart_id;

    assign is_store = i_mem_valid && (i_mem_op == MEM_STORE);
    assign is_lr    = i_mem_valid && (i_mem_op == MEM_LR);
    assign is_sc    = i_mem_valid && (i_mem_op == MEM_SC);

    always_comb begin
        tag_match = '0;
        for (int k = 0; k < NUM_HARTS; k++)
            tag_match[k] = (res_tag[k] == mem_tag);
    end

    assign sc_ok = is_sc && |(res_valid & tag_match & issuer);

    always_comb begin
        res_valid_nxt = res_valid;
        if (is_lr) begin
            res_valid_nxt = res_valid | issuer;
        end else if (is_store) begin
            // A store to a reserved word breaks every hart's reservation on it,
            // the storing hart included.
            res_valid_nxt = res_valid & ~tag_match;
        end else if (is_sc) begin
            res_valid_nxt = res_valid & ~issuer;
            // A successful SC is a store, so competing reservations on the word die.
            if (sc_ok)
                res_valid_nxt = res_valid_nxt & ~tag_match;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            res_valid    <= '0;
            for (int k = 0; k < NUM_HARTS; k++)
                res_tag[k] <= '0;
            o_sc_done    <= 1'b0;
            o_sc_hart_id <= '0;
            o_sc_success <= 1'b0;
        end else begin
            res_valid <= res_valid_nxt;
            if (is_lr)
                res_tag[i_mem_hart_id] <= mem_tag;
            o_sc_done    <= is_sc;
            o_sc_success <= sc_ok;
            if (is_sc)
                o_sc_hart_id <= i_mem_hart_id;
        end
    end

    assign o_res_valid = res_valid;

endmodule

// File: rtl/hart_ctrl_decoder.sv
// rtl/hart_ctrl_decoder.sv - hart-tagged pipelined control decoder with LR/SC reservation table
//   i_clk, i_rstn                         : clock, asynchronous active-low reset
//   i_valid/_hart_id/_opcode/_funct3/_funct7 : issued instruction fields
//   i_flush, i_flush_hart_id              : kill in-flight entries of one hart
//   o_valid/_hart_id/_ctrl/_illegal       : control bundle, DECODE_STAGES cycles later
//   i_mem_*                               : memory-stage op feeding the reservation table
//   o_sc_*, o_res_valid                   : SC resolution and reservation state
module hart_ctrl_decoder
    import riscv_ctrl_pkg::*;
#(
    parameter int NUM_HARTS     = 16,
    parameter int HART_ID_W     = $clog2(NUM_HARTS),
    parameter int ADDR_W        = 32,
    parameter int DECODE_STAGES = 1,
    parameter int RES_GRANULE   = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_valid,
    input  logic [HART_ID_W-1:0] i_hart_id,
    input  logic [6:0]           i_opcode,
    input  logic [2:0]           i_funct3,
    input  logic [6:0]           i_funct7,
    input  logic                 i_flush,
    input  logic [HART_ID_W-1:0] i_flush_hart_id,
    output logic                 o_valid,
    output logic [HART_ID_W-1:0] o_hart_id,
    output ctrl_t                o_ctrl,
    output logic                 o_illegal,
    input  logic                 i_mem_valid,
    input  logic [HART_ID_W-1:0] i_mem_hart_id,
    input  logic [ADDR_W-1:0]    i_mem_addr,
    input  logic [1:0]           i_mem_op,
    output logic                 o_sc_done,
    output logic [HART_ID_W-1:0] o_sc_hart_id,
    output logic                 o_sc_success,
    output logic [NUM_HARTS-1:0] o_res_valid
);

    logic                 stg_valid [DECODE_STAGES];
    logic [HART_ID_W-1:0] stg_hart  [DECODE_STAGES];
    ctrl_t                stg_ctrl  [DECODE_STAGES];
    logic                 stg_ill   [DECODE_STAGES];
    decode_t              dec;

    assign dec = decode_ctrl(i_opcode, i_funct3, i_funct7);

    // Flush is applied on every capture, so an entry of the flushed hart is
    // dropped whether it is entering stage 0 or advancing between stages.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int s = 0; s < DECODE_STAGES; s++) begin
                stg_valid[s] <= 1'b0;
                stg_hart[s]  <= '0;
                stg_ctrl[s]  <= '0;
                stg_ill[s]   <= 1'b0;
            end
        end else begin
            stg_valid[0] <= i_valid && !(i_flush && (i_flush_hart_id == i_hart_id));
            stg_hart[0]  <= i_hart_id;
            stg_ctrl[0]  <= dec.ctrl;
            stg_ill[0]   <= dec.illegal;
            for (int s = 1; s < DECODE_STAGES; s++) begin
                stg_valid[s] <= stg_valid[s-1] &&
                                !(i_flush && (i_flush_hart_id == stg_hart[s-1]));
                stg_hart[s]  <= stg_hart[s-1];
                stg_ctrl[s]  <= stg_ctrl[s-1];
                stg_ill[s]   <= stg_ill[s-1];
            end
        end
    end

    assign o_valid   = stg_valid[DECODE_STAGES-1];
    assign o_hart_id = stg_hart[DECODE_STAGES-1];
    assign o_ctrl    = stg_ctrl[DECODE_STAGES-1];
    assign o_illegal = stg_ill[DECODE_STAGES-1];

    // The memory stage is past the flush point, so the table ignores i_flush.
    lrsc_reservation_table #(
        .NUM_HARTS   (NUM_HARTS),
        .HART_ID_W   (HART_ID_W),
        .ADDR_W      (ADDR_W),
        .RES_GRANULE (RES_GRANULE)
    ) u_res_table (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_mem_valid   (i_mem_valid),
        .i_mem_hart_id (i_mem_hart_id),
        .i_mem_addr    (i_mem_addr),
        .i_mem_op      (i_mem_op),
        .o_sc_done     (o_sc_done),
        .o_sc_hart_id  (o_sc_hart_id),
        .o_sc_success  (o_sc_success),
        .o_res_valid   (o_res_valid)
    );

endmodule
